cla_subtractor_9bit_pipe: RTL

Two-stage pipelined 9-bit carry-lookahead subtractor with valid/ready handshakes on both sides. It computes minuend minus subtrahend as A + ~B + 1 using grouped generate/propagate lookahead, and reports a borrow flag in the top result bit. It is the inverse-direction companion to the team's combinational 9-bit lookahead adder. It sits in the same datapath wherever a registered, flow-controlled difference is needed.

---
 rtl/cla_subtractor_9bit_pipe_if.sv | 30 +++
 rtl/cla_subtractor_9bit_pipe.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cla_subtractor_9bit_pipe_if.sv
// Operand/result handshake bundle for the pipelined 9-bit lookahead subtractor.
interface cla_subtractor_9bit_pipe_if;
  logic [8:0] i_minuend;
  logic [8:0] i_subtrahend;
  logic       i_valid;
  logic       o_ready;
  logic [9:0] o_result;
  logic       o_valid;
  logic       i_ready;

  modport slave (
    input  i_minuend,
    input  i_subtrahend,
    input  i_valid,
    output o_ready,
    output o_result,
    output o_valid,
    input  i_ready
  );

  modport master (
    output i_minuend,
    output i_subtrahend,
    output i_valid,
    input  o_ready,
    input  o_result,
    input  o_valid,
    output i_ready
  );
endinterface

// File: rtl/cla_subtractor_9bit_pipe.sv
// Two-stage 9-bit carry-lookahead subtractor (A + ~B + 1) with valid/ready on both sides.
// Stage 1 holds p/g and the low-group carry c4; stage 2 holds the difference and borrow.
module cla_subtractor_9bit_pipe (
  input  logic                          i_clk,
  input  logic                          i_rst,
  cla_subtractor_9bit_pipe_if.slave     bus
);

  // Flattened sum-of-products carry out of bit 'top' for a group of up to 5 bits.
  function automatic logic group_carry(
    input logic [4:0] p,
    input logic [4:0] g,
    input logic       cin,
    input int         top
  );
    logic c;
    logic term;
    c = cin;
    for (int m = 0; m < 5; m++) begin
      c = c & ((m <= top) ? p[m] : 1'b1);
    end
    for (int j = 0; j < 5; j++) begin
      term = (j <= top) ? g[j] : 1'b0;
      for (int m = 0; m < 5; m++) begin
        term = term & ((m > j && m <= top) ? p[m] : 1'b1);
      end
      c = c | term;
    end
    return c;
  endfunction

  logic       s1_valid_q, s1_valid_d;
  logic       s2_valid_q, s2_valid_d;
  logic [8:0] p_q, p_d;
  logic [8:0] g_q, g_d;
  logic       c4_q, c4_d;
  logic [9:0] result_q, result_d;

  logic [8:0] p_s;
  logic [8:0] g_s;
  logic       c4_s;
  logic [9:0] carry_s;
  logic [8:0] diff_s;
  logic       adv1_s;
  logic       adv2_s;
  logic       s2_free_s;
  logic       ready_s;
  logic       accept_s;

  // Stage-1 arithmetic: per-bit propagate/generate of A + ~B and the low-group carry.
  always_comb begin
    p_s  = bus.i_minuend ^ ~bus.i_subtrahend;
    g_s  = bus.i_minuend & ~bus.i_subtrahend;
    c4_s = group_carry({1'b0, p_s[3:0]}, {1'b0, g_s[3:0]}, 1'b1, 3);
  end

  // Stage-2 arithmetic: c1..c3 recomputed from c0, c5..c9 looked ahead from registered c4.
  always_comb begin
    carry_s    = 10'b0;
    carry_s[0] = 1'b1;
    for (int i = 1; i < 4; i++) begin
      carry_s[i] = group_carry({1'b0, p_q[3:0]}, {1'b0, g_q[3:0]}, 1'b1, i - 1);
    end
    carry_s[4] = c4_q;
    for (int i = 5; i < 10; i++) begin
      carry_s[i] = group_carry(p_q[8:4], g_q[8:4], c4_q, i - 5);
    end
    diff_s = p_q ^ carry_s[8:0];
  end

  // Flow control; o_ready never looks at i_valid.
  always_comb begin
    adv2_s    = s2_valid_q & bus.i_ready;
    s2_free_s = ~s2_valid_q | adv2_s;
    adv1_s    = s1_valid_q & s2_free_s;
    ready_s   = ~s1_valid_q | adv1_s;
    accept_s  = bus.i_valid & ready_s;
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    p_d        = p_q;
    g_d        = g_q;
    c4_d       = c4_q;
    result_d   = result_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      p_d        = p_s;
      g_d        = g_s;
      c4_d       = c4_s;
    end else if (adv1_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (adv1_s) begin
      s2_valid_d = 1'b1;
      result_d   = {~carry_s[9], diff_s};
    end else if (adv2_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Control and output registers; reset discards everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= 10'h000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
    end
  end

  // Stage-1 payload; meaningful only while s1_valid_q is set.
  always_ff @(posedge i_clk) begin
    p_q  <= p_d;
    g_q  <= g_d;
    c4_q <= c4_d;
  end

  assign bus.o_ready  = ready_s;
  assign bus.o_valid  = s2_valid_q;
  assign bus.o_result = result_q;

endmodule
